// File: rtl/wb_stream_fifo_bridge.sv
// Wishbone-to-byte-stream bridge: NUM_CH channels, each with RX/TX FIFOs and IRQ registers.
// Optional feature macro: WBFB_IRQ_WATERMARK_EN (RX interrupt on a programmable fill watermark).
module wb_stream_fifo_bridge #(
    parameter int          NUM_CH          = 2,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter int          ADDRWIDTH       = 7,
    parameter logic [31:0] DEF_REG_VALUE   = 32'hFAB_DEF_AC
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_i,
    input  logic [ADDRWIDTH-1:0]  WBs_ADR_i,
    input  logic                  WBs_CYC_i,
    input  logic                  WBs_STB_i,
    input  logic                  WBs_WE_i,
    input  logic [3:0]            WBs_BYTE_STB_i,
    input  logic [31:0]           WBs_DAT_i,
    output logic [31:0]           WBs_DAT_o,
    output logic                  WBs_ACK_o,
    input  logic [8*NUM_CH-1:0]   rx_data_i,
    input  logic [NUM_CH-1:0]     rx_valid_i,
    output logic [NUM_CH-1:0]     rx_ready_o,
    output logic [8*NUM_CH-1:0]   tx_data_o,
    output logic [NUM_CH-1:0]     tx_valid_o,
    input  logic [NUM_CH-1:0]     tx_ready_i,
    output logic                  Interrupt_o
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int CW    = ADDRWIDTH - 2;

    logic                   ack_q;
    logic [31:0]            dat_q;
    logic [31:0]            dat_d;
    logic                   irq_q;
    logic                   acc;
    logic [1:0]             reg_sel;
    logic [CW-1:0]          chan;
    logic                   chan_ok;
    logic [NUM_CH-1:0]      irq_ch;
    logic [NUM_CH-1:0][31:0] rd_ch;
    logic                   unused_bits;

    // Side effects fire on the edge that raises ACK, so each access acts once.
    assign acc     = WBs_CYC_i & WBs_STB_i & ~ack_q;
    assign reg_sel = WBs_ADR_i[1:0];
    assign chan    = WBs_ADR_i[ADDRWIDTH-1:2];
    assign chan_ok = int'(chan) < NUM_CH;
    assign unused_bits = ^{WBs_DAT_i[31:8], WBs_BYTE_STB_i[3:1]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]    rx_mem_q [DEPTH];
        logic [7:0]    tx_mem_q [DEPTH];
        logic [PW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
        logic [LW-1:0] rx_lvl_q, tx_lvl_q;
        logic          rx_ovf_q, tx_ovf_q, rx_udf_q;
        logic [3:0]    en_q;
        logic [7:0]    wm_rd;
        logic          sel, data_rd, data_wr, stat_wr, en_wr;
        logic          rx_empty, rx_full, tx_empty, tx_full;
        logic          rx_push, rx_pop, tx_push, tx_pop, pending;
        logic [3:0]    int_stat;
        logic [31:0]   rd_v;

        assign sel      = acc & chan_ok & (int'(chan) == c);
        assign data_rd  = sel & ~WBs_WE_i & (reg_sel == 2'd0);
        assign data_wr  = sel & WBs_WE_i & (reg_sel == 2'd0) & WBs_BYTE_STB_i[0];
        assign en_wr    = sel & WBs_WE_i & (reg_sel == 2'd2);
        assign stat_wr  = sel & WBs_WE_i & (reg_sel == 2'd3) & WBs_BYTE_STB_i[0];
        assign rx_empty = rx_lvl_q == '0;
        assign rx_full  = rx_lvl_q == LW'(DEPTH);
        assign tx_empty = tx_lvl_q == '0;
        assign tx_full  = tx_lvl_q == LW'(DEPTH);
        assign rx_pop   = data_rd & ~rx_empty;
        // A full RX still accepts a byte when the bus pops in the same cycle.
        assign rx_push  = rx_valid_i[c] & (~rx_full | rx_pop);
        assign tx_pop   = ~tx_empty & tx_ready_i[c];
        assign tx_push  = data_wr & ~tx_full;

        always_ff @(posedge WBs_CLK_i) begin
            if (rx_push) rx_mem_q[rx_wr_q] <= rx_data_i[8*c +: 8];
            if (tx_push) tx_mem_q[tx_wr_q] <= WBs_DAT_i[7:0];
        end

        always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
            if (!WBs_RST_i) begin
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
                tx_wr_q  <= '0;
                tx_rd_q  <= '0;
                rx_lvl_q <= '0;
                tx_lvl_q <= '0;
                rx_ovf_q <= 1'b0;
                tx_ovf_q <= 1'b0;
                rx_udf_q <= 1'b0;
                en_q     <= '0;
            end else begin
                if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
                if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
                if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
                if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
                rx_lvl_q <= rx_lvl_q + LW'(rx_push) - LW'(rx_pop);
                tx_lvl_q <= tx_lvl_q + LW'(tx_push) - LW'(tx_pop);
                if (rx_valid_i[c] & rx_full & ~rx_pop) rx_ovf_q <= 1'b1;
                else if (stat_wr & WBs_DAT_i[2])        rx_ovf_q <= 1'b0;
                if (data_wr & tx_full)                  tx_ovf_q <= 1'b1;
                else if (stat_wr & WBs_DAT_i[3])        tx_ovf_q <= 1'b0;
                if (data_rd & rx_empty)                 rx_udf_q <= 1'b1;
                else if (stat_wr & WBs_DAT_i[4])        rx_udf_q <= 1'b0;
                if (en_wr & WBs_BYTE_STB_i[0])          en_q <= WBs_DAT_i[3:0];
            end
        end

`ifdef WBFB_IRQ_WATERMARK_EN
        logic [7:0] wm_q;
        always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
            if (!WBs_RST_i)                       wm_q <= 8'h01;
            else if (en_wr & WBs_BYTE_STB_i[1])   wm_q <= WBs_DAT_i[15:8];
        end
        assign wm_rd   = wm_q;
        assign pending = 8'(rx_lvl_q) >= ((wm_q == 8'h0) ? 8'h01 : wm_q);
`else
        assign wm_rd   = 8'h00;
        assign pending = ~rx_empty;
`endif

        assign int_stat = {tx_ovf_q, rx_ovf_q, tx_empty, pending};
        assign irq_ch[c] = |(int_stat & en_q);

        always_comb begin
            rd_v = 32'h0;
            unique case (reg_sel)
                2'd0: rd_v = rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rd_q]};
                2'd1: rd_v = {11'h0, rx_udf_q, tx_ovf_q, rx_ovf_q,
                              tx_full, rx_empty, 8'(tx_lvl_q), 8'(rx_lvl_q)};
                2'd2: rd_v = {16'h0, wm_rd, 4'h0, en_q};
                2'd3: rd_v = {28'h0, int_stat};
            endcase
        end

        assign rd_ch[c]           = rd_v;
        assign tx_data_o[8*c +: 8] = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
        assign tx_valid_o[c]      = ~tx_empty;
        assign rx_ready_o[c]      = ~rx_full;
    end

    always_comb begin
        dat_d = DEF_REG_VALUE;
        for (int c = 0; c < NUM_CH; c++)
            if (chan_ok && int'(chan) == c) dat_d = rd_ch[c];
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
        if (!WBs_RST_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= acc;
            if (acc & ~WBs_WE_i) dat_q <= dat_d;
            irq_q <= |irq_ch;
        end
    end

    assign WBs_ACK_o   = ack_q;
    assign WBs_DAT_o   = dat_q;
    assign Interrupt_o = irq_q;
endmodule

// File: tb/tb_wb_stream_fifo_bridge.sv
// Scoreboard bench for wb_stream_fifo_bridge: queued expected bus reads and TX bytes.
module tb_wb_stream_fifo_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  adr = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  bstb = 4'hF;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        ack;
    logic [15:0] rx_data = '0;
    logic [1:0]  rx_valid = '0;
    logic [1:0]  rx_ready;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready = '0;
    logic        irq;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic [7:0]  txq[$];

    always #5 clk = ~clk;

    wb_stream_fifo_bridge dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst_n), .WBs_ADR_i(adr),
        .WBs_CYC_i(cyc), .WBs_STB_i(stb), .WBs_WE_i(we),
        .WBs_BYTE_STB_i(bstb), .WBs_DAT_i(wdat), .WBs_DAT_o(rdat),
        .WBs_ACK_o(ack), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .Interrupt_o(irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] a(input int ch, input int r);
        return 7'(ch * 4 + r);
    endfunction

    // Bus read monitor
    always @(negedge clk) begin
        if (ack && !we) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_read: got %h expected none", rdat);
            end else begin
                check(nm_q.pop_front(), rdat, exp_q.pop_front());
            end
        end
    end

    // TX stream monitor, channel 1
    always @(negedge clk) begin
        if (tx_valid[1] && tx_ready[1]) begin
            if (txq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_tx: got %h expected none", tx_data[15:8]);
            end else begin
                check("tx_byte", {24'h0, tx_data[15:8]}, {24'h0, txq.pop_front()});
            end
        end
    end

    task automatic wb_cycle(input logic [6:0] ad, input logic w, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        adr = ad; we = w; wdat = d; bstb = 4'hF; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 10);
        if (!ack) check("ack_timeout", 32'(ack), 32'h1);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("ack_pulse", 32'(ack), 32'h0);
    endtask

    task automatic wb_read(input logic [6:0] ad, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        wb_cycle(ad, 1'b0, 32'h0);
    endtask

    task automatic wb_write(input logic [6:0] ad, input logic [31:0] d);
        wb_cycle(ad, 1'b1, d);
    endtask

    task automatic rx_push0(input logic [7:0] d);
        @(posedge clk); #1;
        rx_data[7:0] = d; rx_valid[0] = 1'b1;
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h3);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        rst_n = 1'b1;
        wait_cycles(2);

        wb_read(a(0, 1), 32'h0001_0000, "st0_reset");
`ifdef WBFB_IRQ_WATERMARK_EN
        wb_read(a(0, 2), 32'h0000_0100, "inten_reset");
`else
        wb_read(a(0, 2), 32'h0000_0000, "inten_reset");
`endif

        // TX path on channel 1
        wb_write(a(1, 0), 32'h41);
        wb_write(a(1, 0), 32'h42);
        wb_read(a(1, 1), 32'h0001_0200, "st1_tx2");
        check("tx_valid_hold", 32'(tx_valid[1]), 32'h1);
        check("tx_head", 32'(tx_data[15:8]), 32'h41);
        txq.push_back(8'h41);
        txq.push_back(8'h42);
        tx_ready[1] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (tx_valid[1] && n < 20);
        tx_ready[1] = 1'b0;
        check("tx_drain", 32'(tx_valid[1]), 32'h0);
        check("txq_empty", 32'(txq.size()), 32'h0);
        wb_read(a(1, 1), 32'h0001_0000, "st1_drained");

        // RX overflow on channel 0
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            rx_data[7:0] = 8'(8'h10 + i); rx_valid[0] = 1'b1;
        end
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
        check("rx_ready_full", 32'(rx_ready[0]), 32'h0);
        wb_read(a(0, 1), 32'h0004_0010, "st0_full_ovf");
        wb_read(a(0, 3), 32'h0000_0007, "is0_ovf");
        wb_write(a(0, 3), 32'h4);
        wb_read(a(0, 3), 32'h0000_0003, "is0_cleared");
        wb_read(a(0, 1), 32'h0000_0010, "st0_full");
        for (int i = 0; i < 16; i++)
            wb_read(a(0, 0), 32'(8'h10 + i), "rx_byte");
        wb_read(a(0, 1), 32'h0001_0000, "st0_drained");

        // Underflow
        wb_read(a(0, 0), 32'h0, "rx_empty_read");
        wb_read(a(0, 1), 32'h0011_0000, "st0_udf");
        wb_write(a(0, 3), 32'h10);
        wb_read(a(0, 1), 32'h0001_0000, "st0_udf_clr");

        // Interrupt, watermark 3 when the feature is built in
        wb_write(a(0, 2), 32'h0301);
`ifdef WBFB_IRQ_WATERMARK_EN
        wb_read(a(0, 2), 32'h0000_0301, "inten_rb");
`else
        wb_read(a(0, 2), 32'h0000_0001, "inten_rb");
`endif
        wait_cycles(2);
        check("irq_idle", 32'(irq), 32'h0);
        rx_push0(8'hA1);
        wait_cycles(2);
`ifdef WBFB_IRQ_WATERMARK_EN
        check("irq_b1", 32'(irq), 32'h0);
`else
        check("irq_b1", 32'(irq), 32'h1);
`endif
        rx_push0(8'hA2);
        wait_cycles(2);
`ifdef WBFB_IRQ_WATERMARK_EN
        check("irq_b2", 32'(irq), 32'h0);
`else
        check("irq_b2", 32'(irq), 32'h1);
`endif
        rx_push0(8'hA3);
        wait_cycles(2);
        check("irq_b3", 32'(irq), 32'h1);
        wb_read(a(0, 0), 32'hA1, "irq_rd1");
        wb_read(a(0, 0), 32'hA2, "irq_rd2");
        wb_read(a(0, 0), 32'hA3, "irq_rd3");
        wait_cycles(2);
        check("irq_clear", 32'(irq), 32'h0);

        // Unmapped channel
        wb_read(a(2, 0), 32'hFAB_DEF_AC, "unmapped_data");
        wb_read(a(3, 1), 32'hFAB_DEF_AC, "unmapped_st");
        wb_write(a(2, 0), 32'h55);
        wait_cycles(2);
        check("unmapped_no_tx", 32'(tx_valid), 32'h0);
        wb_read(a(1, 1), 32'h0001_0000, "st1_after_unmapped");
        wb_read(a(0, 1), 32'h0001_0000, "st0_after_unmapped");

        wait_cycles(3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_stream_fifo_bridge.md
# wb_stream_fifo_bridge

Parametrised Wishbone-to-byte-stream bridge that generalises the fixed two-FIFO USB-serial path into NUM_CH independent channels. Each channel has an RX FIFO (stream to M4) and a TX FIFO (M4 to stream), plus per-channel status, interrupt-enable and sticky interrupt-status registers. The block sits on the WB_CLK domain behind the AHB-to-FPGA bridge decoder and drives the single combined Interrupt_o to the M4.

## Interface
- NUM_CH, 2: channel count, 1..8
- FIFO_DEPTH_LOG2, 4: FIFO depth = 2**FIFO_DEPTH_LOG2, range 2..7
- ADDRWIDTH, 7: word address width; ADDRWIDTH ≥ clog2(NUM_CH)+2
- DEF_REG_VALUE, 32'hFAB_DEF_AC: read value for unmapped addresses
- WBs_CLK_i  in  1  bus and stream clock
- WBs_RST_i  in  1  asynchronous, active-low reset
- WBs_ADR_i  in  ADDRWIDTH  word address: [1:0] register, [ADDRWIDTH-1:2] channel
- WBs_CYC_i, WBs_STB_i, WBs_WE_i  in  1  Wishbone cycle, strobe, write enable
- WBs_BYTE_STB_i  in  4  byte enables
- WBs_DAT_i  in  32  write data
- WBs_DAT_o  out  32  registered read data
- WBs_ACK_o  out  1  transfer acknowledge
- rx_data_i  in  8*NUM_CH  inbound bytes, channel c at [8c+7:8c]
- rx_valid_i  in  NUM_CH  inbound byte strobe (upstream cannot stall)
- rx_ready_o  out  NUM_CH  ~rx_full, advisory
- tx_data_o  out  8*NUM_CH  outbound head byte (show-ahead)
- tx_valid_o  out  NUM_CH  ~tx_empty
- tx_ready_i  in  NUM_CH  pops TX when tx_valid_o & tx_ready_i
- Interrupt_o  out  1  registered OR of enabled pending interrupts

## Operation
- Per-channel registers: 0 DATA, 1 STATUS, 2 INT_EN, 3 INT_STAT. Channel index ≥ NUM_CH: reads DEF_REG_VALUE, writes ignored, still acked.
- DATA write (BYTE_STB[0]=1): push WBs_DAT_i[7:0] to TX; if TX full, byte dropped, tx_overflow set. DATA read: returns {24'h0, RX head}, pops RX; if RX empty returns 32'h0, rx_underflow set.
- STATUS (RO): [7:0] rx_level, [15:8] tx_level, [16] rx_empty, [17] tx_full, [18] rx_overflow, [19] tx_overflow, [20] rx_underflow; others 0.
- RX push: every rx_valid_i cycle; if full, byte dropped, rx_overflow set.
- INT_EN (RW, byte-strobed): [3:0] enables; [15:8] rx_watermark (see Configuration).
- INT_STAT: [0] rx_pending (level-based), [1] tx_empty (level), [2] rx_overflow sticky, [3] tx_overflow sticky. Write-1-to-clear on [3:2] clears the matching STATUS sticky bit; rx_underflow clears on any INT_STAT write with bit 4 set.
- Set and clear of a sticky bit in the same cycle: set wins.
- Levels are FIFO_DEPTH_LOG2+1 bits, zero-extended to 8. Pointers wrap modulo depth; full = level==depth.
- Simultaneous push and pop on a non-full, non-empty FIFO: level unchanged. On a full RX: pop first, push accepted. On an empty TX: push only, tx_valid_o rises next cycle.

## Timing
- ACK: asserted one cycle after CYC&STB while ACK low; deasserted the following cycle (one-cycle pulse, one per access). Side effects (push/pop/W1C) occur in the ACK cycle only.
- WBs_DAT_o valid in the ACK cycle; holds otherwise.
- Stream pop/push take effect at the clock edge; tx_data_o shows the next head one cycle after pop.
- Interrupt_o lags the INT_STAT/INT_EN change by one cycle.
- Reset (any time, including mid-access): all FIFOs empty, levels 0, stickies 0, INT_EN 0, WBs_ACK_o 0, WBs_DAT_o 0, Interrupt_o 0, tx_valid_o 0, rx_ready_o all 1, tx_data_o 0. In-flight access is abandoned without ACK.

## Configuration
- WBFB_IRQ_WATERMARK_EN defined: rx_pending = rx_level ≥ max(INT_EN[15:8],1); INT_EN[15:8] RW, reset 8'h01.
- Undefined: rx_pending = ~rx_empty; INT_EN[15:8] reads 0, writes ignored.

## Test plan
- Reset then read ch0 STATUS -> 32'h0001_0000 (rx_empty); Interrupt_o 0; rx_ready_o all 1.
- Write 0x41,0x42 to ch1 DATA, tx_ready_i[1]=0 -> STATUS[15:8]=2; raise tx_ready_i -> tx_data_o[15:8] 0x41 then 0x42, tx_valid_o[1] falls after second pop.
- Depth 16: push 17 bytes on rx_valid_i[0] -> rx_level 16, STATUS[18]=1, INT_STAT[2]=1; write INT_STAT 0x4 -> bit clears; 17th byte never read.
- Read ch0 DATA when empty -> 32'h0, STATUS[20]=1, single ACK pulse.
- INT_EN ch0=0x1, one RX byte -> Interrupt_o 1 (macro on, watermark 1); macro on, watermark 3: asserts only at third byte; read DATA -> deasserts.
- Access channel index NUM_CH -> read 32'hFAB_DEF_AC, ACK pulses, no state change.
